// File: rtl/serial_ucompare.sv
// serial_ucompare: bit-serial unsigned magnitude comparator.
// Two WIDTH-bit operands arrive one bit-pair per VALID/READY handshake,
// LSB first. The result is presented as registered LT/EQ/GT flags with an
// O_VALID/O_READY handshake. Because bits arrive LSB first, a differing
// bit at a more significant position overrides any earlier decision, so
// the LT accumulator tracks the borrow-out of A-B.
module serial_ucompare #(
    parameter int WIDTH = 4
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic START,
    input  logic I0,
    input  logic I1,
    input  logic VALID,
    output logic READY,
    output logic O_LT,
    output logic O_EQ,
    output logic O_GT,
    output logic O_VALID,
    input  logic O_READY
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          lt_acc_q, lt_acc_d;
    logic          gt_acc_q, gt_acc_d;
    logic          eq_acc_q, eq_acc_d;
    logic          o_lt_q, o_lt_d;
    logic          o_eq_q, o_eq_d;
    logic          o_gt_q, o_gt_d;
    logic          o_valid_q, o_valid_d;

    // Accumulator values that would result from accepting the current pair
    logic same_bit;
    logic lt_nx;
    logic gt_nx;
    logic eq_nx;

    assign same_bit = I0 ~^ I1;
    assign lt_nx    = (~I0 & I1) | (same_bit & lt_acc_q);
    assign gt_nx    = (I0 & ~I1) | (same_bit & gt_acc_q);
    assign eq_nx    = eq_acc_q & same_bit;

    // READY depends only on the state, so it never combinationally follows VALID
    assign READY   = (state_q == SHIFT);
    assign O_LT    = o_lt_q;
    assign O_EQ    = o_eq_q;
    assign O_GT    = o_gt_q;
    assign O_VALID = o_valid_q;

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        lt_acc_d  = lt_acc_q;
        gt_acc_d  = gt_acc_q;
        eq_acc_d  = eq_acc_q;
        o_lt_d    = o_lt_q;
        o_eq_d    = o_eq_q;
        o_gt_d    = o_gt_q;
        o_valid_d = o_valid_q;

        case (state_q)
            IDLE: begin
                // VALID is ignored here; only START opens a new comparison
                if (START) begin
                    state_d  = SHIFT;
                    count_d  = '0;
                    lt_acc_d = 1'b0;
                    gt_acc_d = 1'b0;
                    eq_acc_d = 1'b1;
                end
            end
            SHIFT: begin
                // VALID=0 cycles are stalls; START is ignored mid-comparison
                if (VALID) begin
                    lt_acc_d = lt_nx;
                    gt_acc_d = gt_nx;
                    eq_acc_d = eq_nx;
                    if (count_q == LAST_IDX) begin
                        // Final pair: publish flags including this pair's bits
                        state_d   = DONE;
                        count_d   = '0;
                        o_lt_d    = lt_nx;
                        o_eq_d    = eq_nx;
                        o_gt_d    = gt_nx;
                        o_valid_d = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            DONE: begin
                // Flags stay as they are after the handshake, only O_VALID drops
                if (O_READY) begin
                    state_d   = IDLE;
                    o_valid_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                o_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any partial comparison
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= IDLE;
            count_q   <= '0;
            lt_acc_q  <= 1'b0;
            gt_acc_q  <= 1'b0;
            eq_acc_q  <= 1'b0;
            o_lt_q    <= 1'b0;
            o_eq_q    <= 1'b0;
            o_gt_q    <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            lt_acc_q  <= lt_acc_d;
            gt_acc_q  <= gt_acc_d;
            eq_acc_q  <= eq_acc_d;
            o_lt_q    <= o_lt_d;
            o_eq_q    <= o_eq_d;
            o_gt_q    <= o_gt_d;
            o_valid_q <= o_valid_d;
        end
    end

endmodule

// File: tb/tb_serial_ucompare.sv
// Testbench for serial_ucompare: a WIDTH=4 instance exercised with directed
// and randomized comparisons, plus a WIDTH=1 instance for the single-pair case.
// Expected flags come from plain integer comparison of the operands.
module tb_serial_ucompare;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RESETN;
    logic START, I0, I1, VALID, O_READY;
    logic READY, O_LT, O_EQ, O_GT, O_VALID;

    logic s1_START, s1_I0, s1_I1, s1_VALID, s1_O_READY;
    logic s1_READY, s1_O_LT, s1_O_EQ, s1_O_GT, s1_O_VALID;

    int n_checks = 0;
    int n_errs   = 0;

    serial_ucompare #(.WIDTH(4)) dut (
        .CLK(CLK), .RESETN(RESETN), .START(START), .I0(I0), .I1(I1),
        .VALID(VALID), .READY(READY), .O_LT(O_LT), .O_EQ(O_EQ), .O_GT(O_GT),
        .O_VALID(O_VALID), .O_READY(O_READY)
    );

    serial_ucompare #(.WIDTH(1)) dut1 (
        .CLK(CLK), .RESETN(RESETN), .START(s1_START), .I0(s1_I0), .I1(s1_I1),
        .VALID(s1_VALID), .READY(s1_READY), .O_LT(s1_O_LT), .O_EQ(s1_O_EQ),
        .O_GT(s1_O_GT), .O_VALID(s1_O_VALID), .O_READY(s1_O_READY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: unsigned integer compare of the whole operands
    task automatic check_flags(input string tag, input int a, input int b);
        check({tag, ".vld"}, 32'(O_VALID), 32'(1));
        check({tag, ".lt"},  32'(O_LT), 32'(a < b));
        check({tag, ".eq"},  32'(O_EQ), 32'(a == b));
        check({tag, ".gt"},  32'(O_GT), 32'(a > b));
        check({tag, ".onehot"}, 32'(O_LT) + 32'(O_EQ) + 32'(O_GT), 32'(1));
    endtask

    // One full comparison on the WIDTH=4 instance.
    // Stall cycles before each pair: random in [gmin,gmax]; poke drives
    // START (in SHIFT) and START/VALID (in DONE) to show they are ignored.
    task automatic run_cmp(input string tag, input int a, input int b,
                           input int gmin, input int gmax,
                           input int rdy_delay, input bit poke);
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int gaps;
            gaps = (gmax > gmin) ? int'($urandom_range(gmax, gmin)) : gmin;
            repeat (gaps) begin
                VALID = 1'b0;
                I0    = 1'($urandom);
                I1    = 1'($urandom);
                START = poke;
                tick();
                START = 1'b0;
                if (poke) check({tag, ".stall_novld"}, 32'(O_VALID), 32'(0));
            end
            I0    = a[i];
            I1    = b[i];
            VALID = 1'b1;
            check({tag, ".ready"}, 32'(READY), 32'(1));
            tick();
            VALID = 1'b0;
        end
        check_flags(tag, a, b);
        for (int d = 0; d < rdy_delay; d++) begin
            if (poke) begin
                START = 1'b1;
                VALID = 1'b1;
                I0    = 1'($urandom);
                I1    = 1'($urandom);
            end
            check({tag, ".done_rdy"}, 32'(READY), 32'(0));
            tick();
            START = 1'b0;
            VALID = 1'b0;
            check_flags({tag, ".hold"}, a, b);
        end
        O_READY = 1'b1;
        tick();
        O_READY = 1'b0;
        check({tag, ".ack_vld"}, 32'(O_VALID), 32'(0));
        check({tag, ".ack_rdy"}, 32'(READY), 32'(0));
        check({tag, ".ack_keep_lt"}, 32'(O_LT), 32'(a < b));
    endtask

    initial begin
        RESETN = 1'b0;
        START = 1'b0; I0 = 1'b0; I1 = 1'b0; VALID = 1'b0; O_READY = 1'b0;
        s1_START = 1'b0; s1_I0 = 1'b0; s1_I1 = 1'b0; s1_VALID = 1'b0; s1_O_READY = 1'b0;
        repeat (2) tick();

        check("rst.ready", 32'(READY), 32'(0));
        check("rst.ovalid", 32'(O_VALID), 32'(0));
        check("rst.flags", {29'd0, O_LT, O_EQ, O_GT}, 32'(0));
        RESETN = 1'b1;
        tick();

        // Directed cases: basic LT with held result, stalls, GT cases
        run_cmp("t1_3v5", 3, 5, 0, 0, 5, 1'b0);
        run_cmp("t2_9v9", 9, 9, 1, 1, 0, 1'b0);
        run_cmp("t2_15v0", 15, 0, 0, 0, 1, 1'b0);
        run_cmp("t2_8v7", 8, 7, 0, 0, 0, 1'b0);

        // Exhaustive operand sweep with random stalls and result back-pressure
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_cmp("sweep", a, b, 0, 2, int'($urandom_range(3, 0)), 1'b0);
            end
        end

        // Reset in the middle of a comparison (flags currently hold a GT result)
        run_cmp("t4_pre", 14, 3, 0, 0, 0, 1'b0);
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            I0 = 1'b1; I1 = 1'b0; VALID = 1'b1;
            tick();
        end
        VALID = 1'b0;
        RESETN = 1'b0;
        #1;
        check("t4.rst_ready", 32'(READY), 32'(0));
        check("t4.rst_ovalid", 32'(O_VALID), 32'(0));
        check("t4.rst_flags", {29'd0, O_LT, O_EQ, O_GT}, 32'(0));
        tick();
        RESETN = 1'b1;
        tick();
        check("t4.post_ovalid", 32'(O_VALID), 32'(0));
        check("t4.post_ready", 32'(READY), 32'(0));
        run_cmp("t4_2v1", 2, 1, 0, 0, 0, 1'b0);

        // START during SHIFT and START/VALID during DONE are ignored
        run_cmp("t5_poke", 6, 10, 1, 2, 3, 1'b1);

        // VALID in IDLE without START is not accepted
        for (int i = 0; i < 3; i++) begin
            I0 = 1'b1; I1 = 1'b0; VALID = 1'b1;
            check("t5.idle_ready", 32'(READY), 32'(0));
            tick();
            check("t5.idle_ovalid", 32'(O_VALID), 32'(0));
        end
        VALID = 1'b0;
        run_cmp("t5_after_idle", 4, 11, 0, 1, 0, 1'b0);

        // WIDTH=1 instance: single handshake completes the comparison
        s1_START = 1'b1;
        tick();
        s1_START = 1'b0;
        s1_I0 = 1'b0; s1_I1 = 1'b1; s1_VALID = 1'b1;
        check("w1.ready", 32'(s1_READY), 32'(1));
        tick();
        s1_VALID = 1'b0;
        check("w1.vld", 32'(s1_O_VALID), 32'(1));
        check("w1.flags_0v1", {29'd0, s1_O_LT, s1_O_EQ, s1_O_GT}, 32'b100);
        s1_O_READY = 1'b1;
        tick();
        s1_O_READY = 1'b0;
        check("w1.ack", 32'(s1_O_VALID), 32'(0));
        s1_START = 1'b1;
        tick();
        s1_START = 1'b0;
        s1_I0 = 1'b1; s1_I1 = 1'b1; s1_VALID = 1'b1;
        tick();
        s1_VALID = 1'b0;
        check("w1.flags_1v1", {29'd0, s1_O_LT, s1_O_EQ, s1_O_GT}, 32'b010);
        s1_O_READY = 1'b1;
        tick();
        s1_O_READY = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_ucompare.md
Name: serial_ucompare

Overview:
Bit-serial unsigned magnitude comparator. It accepts two WIDTH-bit operands one bit-pair per handshake, LSB first, and produces registered LT/EQ/GT flags. It is the sequential, streamed counterpart of the parallel ULT/subtract-carry comparator. It sits behind serial links and shift-register outputs where the parallel operands are never assembled.

Parameters:
WIDTH, 4, operand width in bits (>=1); number of bit-pairs per comparison.

Ports:
CLK  input  1  clock, all state on rising edge
RESETN  input  1  asynchronous active-low reset
START  input  1  begin a comparison; honoured only in IDLE
I0  input  1  current bit of operand A (LSB first)
I1  input  1  current bit of operand B (LSB first)
VALID  input  1  I0/I1 hold a valid bit-pair
READY  output  1  block accepts a bit-pair this cycle
O_LT  output  1  A < B (unsigned)
O_EQ  output  1  A == B
O_GT  output  1  A > B (unsigned)
O_VALID  output  1  result flags valid
O_READY  input  1  consumer takes result

Behaviour:
- Reset: the clock is CLK. Reset is RESETN, asynchronous and active-low. While RESETN=0: state=IDLE, count=0, READY=0, O_VALID=0, O_LT=0, O_EQ=0, O_GT=0. Reset mid-comparison discards the partial result; no result is emitted.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: READY=0, O_VALID=0. If START=1 -> SHIFT. The transition clears count, lt_acc, gt_acc and eq_acc (eq_acc initialises to 1). VALID in IDLE is ignored.
- SHIFT: READY=1 combinationally, from state only. A bit-pair is accepted on an edge where VALID&READY.
  - lt_acc <= (~I0 & I1) | ((I0 ~^ I1) & lt_acc)
  - gt_acc <= (I0 & ~I1) | ((I0 ~^ I1) & gt_acc)
  - eq_acc <= eq_acc & (I0 ~^ I1)
  - count <= count+1
- The LSB-first rule is the later (more significant) differing bit overriding. It equals the borrow-out of A-B.
- Cycles with VALID=0 are stalls: no state change and no timeout.
- On acceptance of pair number WIDTH (count==WIDTH-1): go to DONE. On the same edge, O_LT/O_EQ/O_GT are loaded with the final accumulator values, including that last pair, and O_VALID is set to 1.
- Latency: flags are valid on the cycle after the last bit-pair handshake.
- DONE: READY=0, O_VALID=1, flags held stable.
  - On an edge with O_READY=1: O_VALID<=0 and -> IDLE. Flags keep their last values.
  - START in DONE is ignored, and START in SHIFT is ignored. A new comparison needs a START in IDLE, at the earliest the cycle after the result handshake.
- Invariant: when O_VALID=1, exactly one of O_LT/O_EQ/O_GT is 1.
- Count width: clog2(WIDTH+1). It never exceeds WIDTH-1 when stored.
- WIDTH=1: a single accepted pair goes directly to DONE.

Test Plan:
1. Reset, START; feed A=3 (I0 bits 1,1,0,0), B=5 (I1 bits 1,0,1,0), VALID=1 each cycle -> READY high for 4 cycles. O_VALID rises the next cycle with O_LT=1, O_EQ=0, O_GT=0. Hold O_READY=0 for 5 cycles -> flags stable. Pulse O_READY -> IDLE and O_VALID=0.
2. A=9, B=9, with VALID low on alternate cycles -> stalls ignored, O_EQ=1 after the 4th accepted pair. A=15, B=0 -> O_GT=1. A=8, B=7 (LSB lower but MSB higher) -> O_GT=1.
3. Exhaustive sweep of all 256 (A,B) pairs at WIDTH=4 with random VALID gaps and random O_READY delay -> flags match the unsigned reference compare. Exactly one flag is set.
4. Assert RESETN=0 after 2 accepted pairs -> outputs immediately 0, no O_VALID. After release, START and A=2, B=1 -> O_GT=1 with no residue from the aborted run.
5. START and VALID pulses in DONE and in SHIFT -> no restart, count unaffected. VALID in IDLE without START -> no acceptance (READY=0).
6. WIDTH=1 build: START, I0=0, I1=1 -> O_LT=1 one cycle after the single handshake.
